conv_engine_param: RTL and testbench
====================================

# conv_engine_param

Parametrised single-output-channel 2-D convolution engine for the CNN datapath. Generalises the fixed `cff` core to configurable image size, kernel size, input-channel count and data width, with output saturation and a runtime ReLU mode. It reads input features and weights from external synchronous RAMs, accumulates each K×K×IN_CH window, and emits one fixed-point result per output pixel with a valid strobe and pixel address.

## Interface
- DATA_WIDTH, 16: signed feature, weight and result width.
- FRAC_BITS, 8: fractional bits of the Q format; identical for features, weights and result.
- IN_FEATURE_ADDR_WIDTH, 11: feature RAM address width.
- WEIGHT_ADDR_WIDTH, 8: weight RAM address width.
- IMG_W, 32 / IMG_H, 32: input image width and height.
- KERNEL, 3: kernel side K.
- IN_CH, 1: number of input channels.
- ACC_WIDTH, 40: accumulator width; must be at least 2·DATA_WIDTH + clog2(K·K·IN_CH).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run/advance; low = freeze.
- relu_en  in  1  clamp negative results to 0; must be static while running.
- rd_en  out  1  RAM read enable; RAMs hold read data when low.
- feat_addr  out  IN_FEATURE_ADDR_WIDTH  feature RAM address.
- feat_data  in  DATA_WIDTH  feature read data, 1-cycle latency.
- wgt_addr  out  WEIGHT_ADDR_WIDTH  weight RAM address.
- wgt_data  in  DATA_WIDTH  weight read data, 1-cycle latency.
- finalresult  out  DATA_WIDTH  result of the last completed window.
- out_addr  out  clog2(OUT_W·OUT_H)  output pixel index of finalresult.
- result_valid  out  1  one-cycle strobe qualifying finalresult/out_addr.
- done  out  1  layer complete.

## Operation
- Valid convolution, no padding: OUT_W = IMG_W−K+1, OUT_H = IMG_H−K+1, N = K·K·IN_CH taps per window.
- Tap order: ch outer, then ky, then kx inner. feat_addr = ch·IMG_W·IMG_H + (row+ky)·IMG_W + (col+kx); wgt_addr = ch·K·K + ky·K + kx.
- Windows are raster order (col inner); out_addr = row·OUT_W + col.
- States: IDLE → RUN when enable=1. RUN issues N taps, then goes to DRAIN. DRAIN lasts 2 cycles, then goes to OUT. OUT lasts 1 cycle, then goes to RUN for the next window, or to DONE after the last window. DONE → IDLE when enable=0, which allows a rerun.
- Arithmetic: full-precision signed product, sign-extended into ACC_WIDTH. The accumulator is cleared at the first tap of each window.
- Result path: arithmetic shift right by FRAC_BITS (truncate toward −∞), saturate to [−2^(DW−1), 2^(DW−1)−1], then apply ReLU when relu_en=1.
- rd_en = enable while in RUN.
- enable=0 in any state freezes all state, counters, addresses, pipeline registers and the accumulator. Outputs hold, and result_valid is forced to 0 during the freeze.

## Timing
- Reset values: finalresult=0, out_addr=0, result_valid=0, done=0, rd_en=0, feat_addr=0, wgt_addr=0, state=IDLE.
- Reset takes effect immediately at any point; a partial window is discarded.
- Per-window pipeline:
  - Address of tap i is issued in RUN cycle i.
  - RAM data arrives in cycle i+1.
  - The registered product is available in cycle i+2.
  - The accumulator update completes at the end of cycle N+1.
- finalresult and out_addr are registered at the end of OUT. result_valid is high for exactly the following cycle, which is also the first RUN cycle of the next window.
- Window period is N+3 cycles with enable held high.
- The first result_valid occurs N+4 cycles after the first enable-high cycle in IDLE.
- done rises in the cycle after the last result_valid and stays high until DONE is left or reset is asserted.
- Freeze cycles add exactly their count to all subsequent timing.

## Structure
- Package conv_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, OUT, DONE);
  - localparam derivations (OUT_W, OUT_H, N, out_addr width);
  - the saturate and ReLU function.
- Sub-module conv_mac: product register, accumulator with clear and freeze, and the shift/saturate/ReLU result stage.
- The top level holds the FSM and the address generation.

## Test plan
- IMG 4×4, K=3, IN_CH=1, features 0x0100, weights 0x0100:
  - four results of 0x0900 with out_addr 0..3;
  - period 12 cycles;
  - done after the fourth result.
- Same setup, weights 0xFF00:
  - relu_en=0 → 0xF700 for every output;
  - relu_en=1 → 0x0000 for every output.
- Features and weights 0x7F00 → 0x7FFF (positive saturation). Features 0x7F00 with weights 0x8100 → 0x8000 (negative saturation).
- IN_CH=2, channel 0 features 0x0100, channel 1 features 0x0200, weights 0x0100:
  - every result 0x1B00;
  - period 21 cycles.
- enable low for 5 cycles in the middle of window 1 → identical results, with that result and all later strobes delayed by 5 cycles.
- Reset pulse mid-window 2:
  - all outputs read 0 immediately;
  - after restart, results resume from out_addr 0 with correct values.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state type and helper functions for the parametrised convolution engine.
// Geometry helpers take the engine parameters as arguments so every instance derives its own sizes.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int tap_count(input int k, input int ch);
    return k * k * ch;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp to the signed dw-bit range, then optionally zero negative values.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v, input int dw,
                                                  input logic relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate pipeline: RAM data stage, product register, accumulator, result stage.
// Everything holds while enable is low so a freeze is invisible apart from its delay.
module conv_mac import conv_pkg::*; #(
  parameter int DW = 16,
  parameter int FB = 8,
  parameter int AW = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 relu_en,
  input  logic                 issue,
  input  logic                 issue_first,
  input  logic                 load,
  input  logic signed [DW-1:0] feat_data,
  input  logic signed [DW-1:0] wgt_data,
  output logic        [DW-1:0] result
);

  logic                   data_vld, data_first, prod_vld, prod_first;
  logic signed [2*DW-1:0] prod_q;
  logic signed [AW-1:0]   acc_q, prod_ext;
  logic signed [63:0]     acc_shift;

  always_comb begin
    prod_ext  = $signed({{(AW - 2 * DW){prod_q[2*DW-1]}}, prod_q});
    acc_shift = $signed({{(64 - AW){acc_q[AW-1]}}, acc_q}) >>> FB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_vld   <= 1'b0;
      data_first <= 1'b0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      result     <= '0;
    end else if (enable) begin
      data_vld   <= issue;
      data_first <= issue_first;
      prod_q     <= feat_data * wgt_data;
      prod_vld   <= data_vld;
      prod_first <= data_first;
      if (prod_vld) acc_q <= prod_first ? prod_ext : acc_q + prod_ext;
      if (load) result <= DW'(sat_relu(acc_shift, DW, relu_en));
    end
  end

endmodule

// File: rtl/conv_engine_param.sv
// Single-output-channel K x K x IN_CH valid convolution over an IMG_W x IMG_H image.
// Holds the window FSM and RAM address generation; arithmetic lives in conv_mac.
module conv_engine_param import conv_pkg::*; #(
  parameter  int DATA_WIDTH            = 16,
  parameter  int FRAC_BITS             = 8,
  parameter  int IN_FEATURE_ADDR_WIDTH = 11,
  parameter  int WEIGHT_ADDR_WIDTH     = 8,
  parameter  int IMG_W                 = 32,
  parameter  int IMG_H                 = 32,
  parameter  int KERNEL                = 3,
  parameter  int IN_CH                 = 1,
  parameter  int ACC_WIDTH             = 40,
  localparam int OUT_W                 = out_dim(IMG_W, KERNEL),
  localparam int OUT_H                 = out_dim(IMG_H, KERNEL),
  localparam int OA_W                  = idx_bits(OUT_W * OUT_H)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             relu_en,
  output logic                             rd_en,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0] feat_addr,
  input  logic signed [DATA_WIDTH-1:0]     feat_data,
  output logic [WEIGHT_ADDR_WIDTH-1:0]     wgt_addr,
  input  logic signed [DATA_WIDTH-1:0]     wgt_data,
  output logic [DATA_WIDTH-1:0]            finalresult,
  output logic [OA_W-1:0]                  out_addr,
  output logic                             result_valid,
  output logic                             done
);

  state_t      state, state_nx;
  logic [15:0] kx, ky, ch, col, row;
  logic        dcnt, rv_q, done_q, tap_first, tap_last, win_last, load;
  int          fa_i, wa_i, oa_i;

  always_comb begin
    tap_first = (kx == '0) && (ky == '0) && (ch == '0);
    tap_last  = (kx == 16'(KERNEL - 1)) && (ky == 16'(KERNEL - 1)) && (ch == 16'(IN_CH - 1));
    win_last  = (col == 16'(OUT_W - 1)) && (row == 16'(OUT_H - 1));
    fa_i = int'(ch) * IMG_W * IMG_H + (int'(row) + int'(ky)) * IMG_W + int'(col) + int'(kx);
    wa_i = int'(ch) * KERNEL * KERNEL + int'(ky) * KERNEL + int'(kx);
    oa_i = int'(row) * OUT_W + int'(col);
    feat_addr = IN_FEATURE_ADDR_WIDTH'(fa_i);
    wgt_addr  = WEIGHT_ADDR_WIDTH'(wa_i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // DONE is the one state that reacts to enable low instead of freezing.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (enable && tap_last) state_nx = DRAIN;
      DRAIN:   if (enable && dcnt) state_nx = OUT;
      OUT:     if (enable) state_nx = win_last ? DONE : RUN;
      DONE:    if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_en        = enable && (state == RUN);
    load         = enable && (state == OUT);
    result_valid = rv_q && enable;
    done         = (state == DONE) && done_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kx       <= '0;
      ky       <= '0;
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      dcnt     <= 1'b0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      out_addr <= '0;
    end else begin
      done_q <= (state == DONE) && (done_q || enable);
      if (enable) begin
        rv_q <= (state == OUT);
        case (state)
          RUN: begin
            if (tap_last) begin
              kx <= '0;
              ky <= '0;
              ch <= '0;
            end else if (kx == 16'(KERNEL - 1)) begin
              kx <= '0;
              if (ky == 16'(KERNEL - 1)) begin
                ky <= '0;
                ch <= ch + 16'd1;
              end else begin
                ky <= ky + 16'd1;
              end
            end else begin
              kx <= kx + 16'd1;
            end
          end
          DRAIN: dcnt <= ~dcnt;
          OUT: begin
            out_addr <= OA_W'(oa_i);
            if (win_last) begin
              col <= '0;
              row <= '0;
            end else if (col == 16'(OUT_W - 1)) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
          end
          default: ;
        endcase
      end else if (state == DONE) begin
        rv_q <= 1'b0;
      end
    end
  end

  conv_mac #(.DW(DATA_WIDTH), .FB(FRAC_BITS), .AW(ACC_WIDTH)) u_mac (
    .clk         (clock),
    .rst         (reset),
    .enable      (enable),
    .relu_en     (relu_en),
    .issue       (rd_en),
    .issue_first (tap_first),
    .load        (load),
    .feat_data   (feat_data),
    .wgt_data    (wgt_data),
    .result      (finalresult)
  );

endmodule

// File: tb/tb_conv_engine_param.sv
// Bench for conv_engine_param: two 4x4 K=3 instances (IN_CH=1 and IN_CH=2) sharing one RAM image,
// checked against table constants and a direct convolution model.
module tb_conv_engine_param;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, relu = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] feat_mem [0:2047];
  logic signed [15:0] wgt_mem  [0:255];

  logic               rd_a, rd_b, rv_a, rv_b, dn_a, dn_b;
  logic [10:0]        fa_a, fa_b;
  logic [7:0]         wa_a, wa_b;
  logic signed [15:0] fd_a = '0, wd_a = '0, fd_b = '0, wd_b = '0;
  logic [15:0]        fr_a, fr_b;
  logic [1:0]         oa_a, oa_b;

  conv_engine_param #(.DATA_WIDTH(16), .FRAC_BITS(8), .IN_FEATURE_ADDR_WIDTH(11),
    .WEIGHT_ADDR_WIDTH(8), .IMG_W(4), .IMG_H(4), .KERNEL(3), .IN_CH(1), .ACC_WIDTH(40)) dut_a (
    .clock(clk), .reset(rst), .enable(enable), .relu_en(relu), .rd_en(rd_a),
    .feat_addr(fa_a), .feat_data(fd_a), .wgt_addr(wa_a), .wgt_data(wd_a),
    .finalresult(fr_a), .out_addr(oa_a), .result_valid(rv_a), .done(dn_a));

  conv_engine_param #(.DATA_WIDTH(16), .FRAC_BITS(8), .IN_FEATURE_ADDR_WIDTH(11),
    .WEIGHT_ADDR_WIDTH(8), .IMG_W(4), .IMG_H(4), .KERNEL(3), .IN_CH(2), .ACC_WIDTH(40)) dut_b (
    .clock(clk), .reset(rst), .enable(enable), .relu_en(relu), .rd_en(rd_b),
    .feat_addr(fa_b), .feat_data(fd_b), .wgt_addr(wa_b), .wgt_data(wd_b),
    .finalresult(fr_b), .out_addr(oa_b), .result_valid(rv_b), .done(dn_b));

  // Synchronous RAMs: one-cycle latency, output held while rd_en is low.
  always @(posedge clk) begin
    if (rd_a) begin fd_a <= feat_mem[fa_a]; wd_a <= wgt_mem[wa_a]; end
    if (rd_b) begin fd_b <= feat_mem[fa_b]; wd_b <= wgt_mem[wa_b]; end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int val; int cyc; } rec_t;
  rec_t qa[$], qb[$];
  int done_a_cyc = -1, done_b_cyc = -1, start_cyc = 0;
  int n_checks = 0, n_fail = 0;

  always @(negedge clk) begin
    if (rv_a) qa.push_back('{int'(oa_a), int'(fr_a), cyc});
    if (rv_b) qb.push_back('{int'(oa_b), int'(fr_b), cyc});
    if (dn_a && done_a_cyc < 0) done_a_cyc = cyc;
    if (dn_b && done_b_cyc < 0) done_b_cyc = cyc;
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Direct convolution of output pixel pix over inch channels, Q8.8 result.
  function automatic int ref_pix(input int inch, input int pix, input bit rl);
    longint s = 0;
    int r = pix / 2, c = pix % 2;
    for (int ch = 0; ch < inch; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += longint'(feat_mem[ch*16 + (r+ky)*4 + c + kx]) * longint'(wgt_mem[ch*9 + ky*3 + kx]);
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (rl && s < 0) s = 0;
    return int'(s) & 32'hFFFF;
  endfunction

  task automatic fill(input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin feat_mem[i] = f0; feat_mem[16+i] = f1; end
    for (int i = 0; i < 18; i++) wgt_mem[i] = w;
  endtask

  // Runs one layer on both instances; optional 5-cycle freeze at start+fz.
  task automatic run_layer(input int fz);
    qa.delete(); qb.delete();
    done_a_cyc = -1; done_b_cyc = -1;
    @(posedge clk); #1;
    enable = 1'b1;
    start_cyc = cyc;
    for (int t = 0; t < 400 && !(dn_a && dn_b); t++) begin
      if (fz >= 0 && cyc == start_cyc + fz) begin
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("layer completes within budget", dn_a && dn_b, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("A done clears after enable low", dn_a, 0);
    chk("B done clears after enable low", dn_b, 0);
  endtask

  task automatic check_inst(input string nm, input rec_t q[$], input int dcyc, input int n,
                            input int inch, input bit rl, input int expv, input int fz);
    int nom, last;
    last = 0;
    chk($sformatf("%s result count", nm), q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      nom = start_cyc + n + 4 + k * (n + 3);
      if (fz >= 0 && nom >= start_cyc + fz) nom += 5;
      last = nom;
      if (k < q.size()) begin
        chk($sformatf("%s out_addr[%0d]", nm, k), q[k].addr, k);
        chk($sformatf("%s result[%0d]", nm, k), q[k].val, (expv < 0) ? ref_pix(inch, k, rl) : expv);
        chk($sformatf("%s strobe cycle[%0d]", nm, k), q[k].cyc - start_cyc, nom - start_cyc);
      end
    end
    chk($sformatf("%s done cycle", nm), dcyc - start_cyc, last + 1 - start_cyc);
  endtask

  typedef struct { logic [15:0] f0, f1, w; bit rl; int exp_a, exp_b; } vec_t;
  vec_t tab[5];

  initial begin
    int fz;
    tab[0] = '{16'h0100, 16'h0200, 16'h0100, 1'b0, 32'h0900, 32'h1B00};
    tab[1] = '{16'h0100, 16'h0200, 16'hFF00, 1'b0, 32'hF700, 32'hE500};
    tab[2] = '{16'h0100, 16'h0200, 16'hFF00, 1'b1, 32'h0000, 32'h0000};
    tab[3] = '{16'h7F00, 16'h7F00, 16'h7F00, 1'b0, 32'h7FFF, 32'h7FFF};
    tab[4] = '{16'h7F00, 16'h7F00, 16'h8100, 1'b0, 32'h8000, 32'h8000};
    for (int i = 0; i < 2048; i++) feat_mem[i] = '0;
    for (int i = 0; i < 256; i++) wgt_mem[i] = '0;

    repeat (3) @(posedge clk); #1;
    chk("reset finalresult", fr_a, 0);
    chk("reset out_addr", oa_a, 0);
    chk("reset result_valid", rv_a, 0);
    chk("reset done", dn_a, 0);
    chk("reset rd_en", rd_a, 0);
    chk("reset feat_addr", fa_a, 0);
    chk("reset wgt_addr", wa_a, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fill(tab[i].f0, tab[i].f1, tab[i].w);
      relu = tab[i].rl;
      run_layer(-1);
      check_inst($sformatf("tab%0d A", i), qa, done_a_cyc, 9, 1, tab[i].rl, tab[i].exp_a, -1);
      check_inst($sformatf("tab%0d B", i), qb, done_b_cyc, 18, 2, tab[i].rl, tab[i].exp_b, -1);
    end

    // Freeze inside window 1 of A (window 0 of B).
    fill(16'h0100, 16'h0200, 16'h0100);
    relu = 1'b0;
    run_layer(15);
    check_inst("freeze A", qa, done_a_cyc, 9, 1, 1'b0, 32'h0900, 15);
    check_inst("freeze B", qb, done_b_cyc, 18, 2, 1'b0, 32'h1B00, 15);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) feat_mem[i] = 16'($urandom_range(0, 4095) - 2048);
      for (int i = 0; i < 18; i++) wgt_mem[i] = 16'($urandom_range(0, 4095) - 2048);
      relu = 1'($urandom_range(0, 1));
      fz = (r == 2) ? int'($urandom_range(2, 45)) : -1;
      run_layer(fz);
      check_inst($sformatf("rand%0d A", r), qa, done_a_cyc, 9, 1, relu, -1, fz);
      check_inst($sformatf("rand%0d B", r), qb, done_b_cyc, 18, 2, relu, -1, fz);
    end

    // Reset in the middle of A's window 2, then a clean rerun.
    fill(16'h0100, 16'h0200, 16'h0100);
    relu = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (30) @(posedge clk); #1;
    chk("pre-reset A out_addr", oa_a, 1);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("mid reset finalresult", fr_a, 0);
    chk("mid reset out_addr", oa_a, 0);
    chk("mid reset result_valid", rv_a, 0);
    chk("mid reset done", dn_a, 0);
    chk("mid reset feat_addr", fa_a, 0);
    chk("mid reset wgt_addr", wa_a, 0);
    chk("mid reset B finalresult", fr_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_layer(-1);
    check_inst("post-reset A", qa, done_a_cyc, 9, 1, 1'b0, 32'h0900, -1);
    check_inst("post-reset B", qb, done_b_cyc, 18, 2, 1'b0, 32'h1B00, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
